// File: rtl/data_memory_be.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_be
// Purpose  : Byte-addressed data memory for the MEM stage of the pipelined
//            MIPS core. It supports byte, halfword and word stores with lane
//            selection, and sign- or zero-extended loads. It checks alignment
//            and range, and runs a sequential post-reset clear engine that
//            holds 'busy' high. It also keeps a saturating count of rejected
//            stores and provides a debug tap.
// Ports    : CLK        - clock, rising edge
//            reset      - asynchronous, active-low reset
//            A          - byte address (word index A[31:2], lane A[1:0])
//            WD         - store data, right-justified
//            WE         - store request
//            SIZE       - 00 byte, 01 half, 10 word, 11 reserved
//            UNSIGNED   - 1 = zero-extend loads, 0 = sign-extend
//            RD         - combinational load data
//            busy       - clear engine running; MEM must stall
//            addr_err   - current access misaligned / out of range / bad SIZE
//            err_count  - saturating count of rejected stores
//            test_value - mem[TEST_IDX][15:0]
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_be #(
    parameter int DEPTH    = 256,
    parameter int TEST_IDX = 0,
    parameter int ERR_W    = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      A,
    input  logic [31:0]      WD,
    input  logic             WE,
    input  logic [1:0]       SIZE,
    input  logic             UNSIGNED,
    output logic [31:0]      RD,
    output logic             busy,
    output logic             addr_err,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      test_value
);

    localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0]     c_DEPTH = 30'(DEPTH);
    localparam logic [c_AW-1:0] c_LAST  = c_AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t           r_state;
    logic [c_AW-1:0]  r_clr_idx;
    logic [ERR_W-1:0] r_err_count;
    logic [31:0]      r_mem [DEPTH];

    logic [c_AW-1:0]  w_idx;
    logic             w_busy;
    logic             w_addr_err;
    logic             w_store;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_rd;

    assign w_idx  = A[c_AW+1:2];
    assign w_busy = (r_state == S_CLEAR);

    always_comb begin
        w_addr_err = (A[31:2] >= c_DEPTH);
        case (SIZE)
            2'b00:   ;
            2'b01:   if (A[0])          w_addr_err = 1'b1;
            2'b10:   if (A[1:0] != 2'b00) w_addr_err = 1'b1;
            default: w_addr_err = 1'b1;
        endcase
    end

    assign w_store = !w_busy && WE && !w_addr_err;

    // The array has no reset. The clear engine zeroes it one word per cycle
    // once reset is released. The 'reset' qualifier keeps edges that occur
    // while reset is held from writing.
    always_ff @(posedge CLK) begin
        if (reset && w_busy) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_store) begin
            case (SIZE)
                2'b00:   r_mem[w_idx][{A[1:0], 3'b000} +: 8]  <= WD[7:0];
                2'b01:   r_mem[w_idx][{A[1], 4'b0000} +: 16]  <= WD[15:0];
                default: r_mem[w_idx]                         <= WD;
            endcase
        end
    end

    // Control: clear sequencing and the rejected-store counter. A WE seen
    // while clearing is neither stored nor counted.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state     <= S_CLEAR;
            r_clr_idx   <= '0;
            r_err_count <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_idx == c_LAST) begin
                r_state   <= S_READY;
                r_clr_idx <= '0;
            end else begin
                r_clr_idx <= r_clr_idx + c_AW'(1);
            end
        end else if (WE && w_addr_err && (r_err_count != {ERR_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    // Loads read the current array contents. A store on this same cycle
    // becomes visible only after the edge.
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{A[1:0], 3'b000} +: 8];
    assign w_half = w_word[{A[1], 4'b0000} +: 16];

    always_comb begin
        w_rd = '0;
        if (!w_busy && !w_addr_err) begin
            case (SIZE)
                2'b00:   w_rd = {{24{~UNSIGNED & w_byte[7]}}, w_byte};
                2'b01:   w_rd = {{16{~UNSIGNED & w_half[15]}}, w_half};
                2'b10:   w_rd = w_word;
                default: w_rd = '0;
            endcase
        end
    end

    assign RD         = w_rd;
    assign busy       = w_busy;
    assign addr_err   = w_addr_err;
    assign err_count  = r_err_count;
    assign test_value = w_busy ? 16'h0000 : r_mem[TEST_IDX][15:0];

endmodule
`default_nettype wire

// File: tb/tb_data_memory_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_be
// Purpose  : Directed self-checking bench for data_memory_be. A second
//            instance with ERR_W=2 shares all inputs and exercises counter
//            saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_be;

    logic        CLK;
    logic        reset;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [1:0]  SIZE;
    logic        UNSIGNED;
    logic [31:0] RD;
    logic        busy;
    logic        addr_err;
    logic [7:0]  err_count;
    logic [15:0] test_value;
    logic [31:0] RD2;
    logic        busy2;
    logic        addr_err2;
    logic [1:0]  err_count2;
    logic [15:0] test_value2;

    int tests_run = 0;
    int fails     = 0;

    data_memory_be #(.DEPTH(256), .TEST_IDX(0), .ERR_W(8)) dut (
        .CLK(CLK), .reset(reset), .A(A), .WD(WD), .WE(WE), .SIZE(SIZE),
        .UNSIGNED(UNSIGNED), .RD(RD), .busy(busy), .addr_err(addr_err),
        .err_count(err_count), .test_value(test_value)
    );

    data_memory_be #(.DEPTH(256), .TEST_IDX(0), .ERR_W(2)) dut2 (
        .CLK(CLK), .reset(reset), .A(A), .WD(WD), .WE(WE), .SIZE(SIZE),
        .UNSIGNED(UNSIGNED), .RD(RD2), .busy(busy2), .addr_err(addr_err2),
        .err_count(err_count2), .test_value(test_value2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count rising edges until busy falls (bounded).
    task automatic wait_clear(output int n);
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (busy && n < 2000);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        @(negedge CLK);
        A = a; WD = wd; SIZE = sz; WE = 1'b1;
        @(posedge CLK);
        #1;
        WE = 1'b0;
    endtask

    task automatic setld(input logic [31:0] a, input logic [1:0] sz, input logic u);
        A = a; SIZE = sz; UNSIGNED = u;
        #1;
    endtask

    task automatic test_reset();
        int n;
        @(negedge CLK);
        reset = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_reset: got %b want 1", busy); end
        tests_run++; if (err_count !== 8'd0) begin fails++; $display("FAIL err_reset: got %0d want 0", err_count); end
        repeat (3) @(negedge CLK);
        A = 32'h3FC; SIZE = 2'b10;
        reset = 1'b1;
        wait_clear(n);
        tests_run++; if (n != 256) begin fails++; $display("FAIL clear_len: got %0d edges want 256", n); end
        tests_run++; if (RD !== 32'h0) begin fails++; $display("FAIL rd_3fc_clear: got %h want 0", RD); end
        tests_run++; if (test_value !== 16'h0) begin fails++; $display("FAIL tv_clear: got %h want 0", test_value); end
        // Dirty the memory, then reset from READY and confirm it is wiped.
        store(32'h0, 32'h1234_5678, 2'b10);
        store(32'h3FC, 32'hCAFE_F00D, 2'b10);
        tests_run++; if (test_value !== 16'h5678) begin fails++; $display("FAIL tv_dirty: got %h want 5678", test_value); end
        setld(32'h3FC, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'hCAFE_F00D || addr_err !== 1'b0) begin fails++; $display("FAIL rd_3fc_dirty: got %h err %b want cafef00d err 0", RD, addr_err); end
        @(negedge CLK);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        wait_clear(n);
        tests_run++; if (n != 256) begin fails++; $display("FAIL reclear_len: got %0d edges want 256", n); end
        tests_run++; if (RD !== 32'h0) begin fails++; $display("FAIL rd_3fc_reclear: got %h want 0", RD); end
        tests_run++; if (test_value !== 16'h0) begin fails++; $display("FAIL tv_reclear: got %h want 0", test_value); end
    endtask

    task automatic test_loads();
        store(32'h10, 32'h8081_7F01, 2'b10);
        setld(32'h10, 2'b00, 1'b0);
        tests_run++; if (RD !== 32'h0000_0001) begin fails++; $display("FAIL lb_10: got %h want 00000001", RD); end
        setld(32'h11, 2'b00, 1'b0);
        tests_run++; if (RD !== 32'h0000_007F) begin fails++; $display("FAIL lb_11: got %h want 0000007f", RD); end
        setld(32'h12, 2'b00, 1'b0);
        tests_run++; if (RD !== 32'hFFFF_FF81) begin fails++; $display("FAIL lb_12: got %h want ffffff81", RD); end
        setld(32'h13, 2'b00, 1'b0);
        tests_run++; if (RD !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_13: got %h want ffffff80", RD); end
        setld(32'h13, 2'b00, 1'b1);
        tests_run++; if (RD !== 32'h0000_0080) begin fails++; $display("FAIL lbu_13: got %h want 00000080", RD); end
        setld(32'h12, 2'b01, 1'b0);
        tests_run++; if (RD !== 32'hFFFF_8081) begin fails++; $display("FAIL lh_12: got %h want ffff8081", RD); end
        setld(32'h12, 2'b01, 1'b1);
        tests_run++; if (RD !== 32'h0000_8081) begin fails++; $display("FAIL lhu_12: got %h want 00008081", RD); end
        setld(32'h10, 2'b01, 1'b0);
        tests_run++; if (RD !== 32'h0000_7F01) begin fails++; $display("FAIL lh_10: got %h want 00007f01", RD); end
        setld(32'h10, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'h8081_7F01) begin fails++; $display("FAIL lw_10: got %h want 80817f01", RD); end
    endtask

    task automatic test_partial_stores();
        store(32'h10, 32'h1122_3344, 2'b10);
        store(32'h11, 32'h1234_56AA, 2'b00);
        setld(32'h10, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'h1122_AA44) begin fails++; $display("FAIL sb_11: got %h want 1122aa44", RD); end
        store(32'h12, 32'h5555_BEEF, 2'b01);
        setld(32'h10, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'hBEEF_AA44) begin fails++; $display("FAIL sh_12: got %h want beefaa44", RD); end
        store(32'h13, 32'h0000_0077, 2'b00);
        setld(32'h10, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'h77EF_AA44) begin fails++; $display("FAIL sb_13: got %h want 77efaa44", RD); end
    endtask

    task automatic test_rejects();
        store(32'h0, 32'h5A5A_5A5A, 2'b10);
        store(32'h4, 32'h0BAD_F00D, 2'b10);
        store(32'h8, 32'h0102_0304, 2'b10);
        setld(32'h6, 2'b10, 1'b0);
        tests_run++; if (addr_err !== 1'b1 || RD !== 32'h0) begin fails++; $display("FAIL lw_misalign: err %b rd %h want err 1 rd 0", addr_err, RD); end
        setld(32'h3FC, 2'b10, 1'b0);
        tests_run++; if (addr_err !== 1'b0) begin fails++; $display("FAIL last_word_ok: err %b want 0", addr_err); end
        setld(32'h3FF, 2'b00, 1'b0);
        tests_run++; if (addr_err !== 1'b0) begin fails++; $display("FAIL last_byte_ok: err %b want 0", addr_err); end
        store(32'h6, 32'hFFFF_FFFF, 2'b10);
        store(32'h9, 32'hFFFF_FFFF, 2'b01);
        store(32'h8, 32'hFFFF_FFFF, 2'b11);
        store(32'h400, 32'hFFFF_FFFF, 2'b10);
        setld(32'h4, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'h0BAD_F00D) begin fails++; $display("FAIL rej_word1: got %h want 0badf00d", RD); end
        setld(32'h8, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'h0102_0304) begin fails++; $display("FAIL rej_word2: got %h want 01020304", RD); end
        setld(32'h0, 2'b10, 1'b0);
        tests_run++; if (RD !== 32'h5A5A_5A5A || test_value !== 16'h5A5A) begin fails++; $display("FAIL rej_word0: got %h tv %h want 5a5a5a5a tv 5a5a", RD, test_value); end
        tests_run++; if (err_count !== 8'd4) begin fails++; $display("FAIL err_count4: got %0d want 4", err_count); end
        tests_run++; if (err_count2 !== 2'd3) begin fails++; $display("FAIL err2_after4: got %0d want 3", err_count2); end
        store(32'h401, 32'hFFFF_FFFF, 2'b00);
        tests_run++; if (err_count !== 8'd5) begin fails++; $display("FAIL err_count5: got %0d want 5", err_count); end
        tests_run++; if (err_count2 !== 2'd3) begin fails++; $display("FAIL err2_sat: got %0d want 3", err_count2); end
    endtask

    task automatic test_we_during_clear();
        int n;
        @(negedge CLK);
        reset = 1'b0;
        A = 32'h6; WD = 32'hDEAD_BEEF; SIZE = 2'b10; UNSIGNED = 1'b0; WE = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
            if (n == 5) begin
                tests_run++; if (addr_err !== 1'b1 || RD !== 32'h0 || test_value !== 16'h0) begin fails++; $display("FAIL busy_outputs: err %b rd %h tv %h want 1 0 0", addr_err, RD, test_value); end
            end
            if (n == 100) A = 32'h0;
        end while (busy && n < 2000);
        tests_run++; if (n != 256) begin fails++; $display("FAIL clear_len_we: got %0d edges want 256", n); end
        tests_run++; if (test_value !== 16'h0 || RD !== 32'h0) begin fails++; $display("FAIL we_dropped: tv %h rd %h want 0 0", test_value, RD); end
        tests_run++; if (err_count !== 8'd0) begin fails++; $display("FAIL err_busy: got %0d want 0", err_count); end
        @(posedge CLK);
        #1;
        WE = 1'b0;
        tests_run++; if (test_value !== 16'hBEEF || RD !== 32'hDEAD_BEEF) begin fails++; $display("FAIL first_store: tv %h rd %h want beef deadbeef", test_value, RD); end
    endtask

    task automatic test_midclear_reset_and_same_cycle();
        int n;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        repeat (100) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        wait_clear(n);
        tests_run++; if (n != 256) begin fails++; $display("FAIL midclear_len: got %0d edges want 256", n); end
        @(negedge CLK);
        A = 32'h40; WD = 32'h600D_CAFE; SIZE = 2'b10; UNSIGNED = 1'b0; WE = 1'b1;
        #1;
        tests_run++; if (RD !== 32'h0) begin fails++; $display("FAIL same_cycle_old: got %h want 0", RD); end
        @(posedge CLK);
        #1;
        WD = 32'h1111_1111;
        tests_run++; if (RD !== 32'h600D_CAFE) begin fails++; $display("FAIL next_cycle_new: got %h want 600dcafe", RD); end
        @(posedge CLK);
        #1;
        WE = 1'b0;
        tests_run++; if (RD !== 32'h1111_1111) begin fails++; $display("FAIL back_to_back: got %h want 11111111", RD); end
    endtask

    initial begin
        reset = 1'b0; A = '0; WD = '0; WE = 1'b0; SIZE = 2'b10; UNSIGNED = 1'b0;
        test_reset();
        test_loads();
        test_partial_stores();
        test_rejects();
        test_we_during_clear();
        test_midclear_reset_and_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
Parametrised, byte-addressed data memory for the MEM stage of the pipelined MIPS core. It adds the following over a plain word memory:
- byte, halfword and word stores with lane selection;
- sign- or zero-extended loads;
- misalignment and range checking;
- a sequential post-reset clear engine that stalls the pipeline through a busy flag;
- a saturating fault counter and a debug tap.

Parameters:
DEPTH, 256, number of 32-bit words; 2 <= DEPTH <= 2^16.
TEST_IDX, 0, word index driven onto test_value.
ERR_W, 8, width of err_count.

Ports:
CLK  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
A  input  32  byte address; word index = A[31:2], lane = A[1:0].
WD  input  32  store data, right-justified (byte in WD[7:0], half in WD[15:0]).
WE  input  1  store request for the current cycle.
SIZE  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
UNSIGNED  input  1  1 = zero-extend loads, 0 = sign-extend (lb/lbu, lh/lhu).
RD  output  32  load data, combinational.
busy  output  1  high while clear engine runs; pipeline must stall MEM.
addr_err  output  1  combinational: current access is misaligned, out of range, or SIZE=11.
err_count  output  ERR_W  saturating count of rejected stores.
test_value  output  16  mem[TEST_IDX][15:0], combinational.

Behaviour:
- Reset (async, reset low):
  - state <= CLEAR, clr_idx <= 0, err_count <= 0.
  - Memory array is NOT reset asynchronously.
  - busy = 1 while reset is low.
- CLEAR state:
  - Each rising CLK with reset high writes mem[clr_idx] <= 0 and increments clr_idx.
  - When clr_idx == DEPTH-1 is written, state <= READY.
  - Clear takes exactly DEPTH cycles; busy deasserts on the edge that writes the last word.
- Behaviour while busy:
  - RD = 0, test_value = 0.
  - WE is ignored and not counted as an error.
  - addr_err still reflects A/SIZE.
- Reset mid-clear: engine restarts at clr_idx = 0 after deassertion. Reset during READY re-enters CLEAR.
- addr_err = 1 when any of the following holds:
  - SIZE=11;
  - SIZE=01 and A[0]=1;
  - SIZE=10 and A[1:0]!=0;
  - A[31:2] >= DEPTH.
- Store in READY, WE=1, addr_err=0, on rising CLK:
  - Byte: lane A[1:0] <= WD[7:0].
  - Half: lanes {A[1],1},{A[1],0} <= WD[15:0].
  - Word: full word <= WD.
  - Unselected lanes are unchanged.
- Rejected store (READY, WE=1, addr_err=1):
  - Memory is unchanged.
  - err_count increments and saturates at 2^ERR_W-1 (no wrap).
- Load, combinational from the current array contents:
  - Byte: lane A[1:0], extended per UNSIGNED.
  - Half: lane pair A[1], extended per UNSIGNED.
  - Word: raw word.
  - If addr_err=1, RD = 0.
- Store/load to the same address in one cycle: RD shows the old data. The new data is visible the cycle after the edge; there is no write-through bypass.
- WE is sampled only in READY. A WE held during the final CLEAR cycle is dropped; the first accepted store is on the edge after busy falls.
- Little-endian lane order: lane 0 = bits [7:0].

Test Plan:
1. Reset low 3 cycles, release, count edges until busy falls -> exactly DEPTH (256) edges. Then RD=0 at A=0x3FC, and test_value=0 after preloading garbage via a backdoor before reset.
2. Word store WD=0x8081_7F01 at A=0x10, then loads at A=0x10..0x13:
   - SIZE=00, UNSIGNED=0 at 0x10, 0x11, 0x12, 0x13 -> 0x0000_0001, 0x0000_007F, 0xFFFF_FF81, 0xFFFF_FF80.
   - UNSIGNED=1 at 0x13 -> 0x0000_0080.
   - Half at 0x12, signed -> 0xFFFF_8081.
3. Byte store 0xAA to A=0x11 over word 0x1122_3344 -> word reads 0x1122_AA44. Half store 0xBEEF to A=0x12 -> 0xBEEF_AA44.
4. Rejected stores, each leaving memory unchanged:
   - word store at A=0x6, half at A=0x9, SIZE=11, A=DEPTH*4 -> addr_err=1, err_count=4.
   - With ERR_W=2, 5 rejected stores -> err_count holds at 3.
5. WE=1 with WD=0xDEAD_BEEF at A=0 throughout CLEAR -> mem[0]=0 and test_value=0 after busy falls. Next-cycle store to A=0 -> test_value=0xBEEF.
6. Assert reset at clr_idx=100, release -> busy stays high for a further full DEPTH cycles. Store/read same address same cycle -> RD shows old value, new value on the next cycle.
